// File: rtl/eh2_pkg.sv
// Shared types and helpers for the multi-thread instruction fetch controller.
package eh2_pkg;

  localparam int IFC_MAX_THREADS = 4;
  localparam int IFC_TID_W       = $clog2(IFC_MAX_THREADS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WFM   = 2'd3
  } ifc_mt_state_t;

  // pc is held as address bits [31:1]; a fetch covers 8 bytes, so step the [31:3] field
  function automatic logic [30:0] ifc_seq_next(input logic [30:0] pc);
    return {pc[30:2] + 29'd1, 2'b00};
  endfunction

endpackage

// File: rtl/eh2_ifu_ifc_mt_ctl_chk.sv
// Protocol checks for the fetch controller: consumers may not drain more than is held.
module eh2_ifu_ifc_mt_ctl_chk #(
  parameter int NUM_THREADS = 2,
  parameter int CW          = 3
) (
  input logic                      clk,
  input logic                      rst_l,
  input logic [NUM_THREADS-1:0]    flush,
  input logic [NUM_THREADS*2-1:0]  fb_consume,
  input logic [NUM_THREADS*CW-1:0] cnt_flat
);

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_chk
    a_consume_le_count: assert property (
      @(posedge clk) disable iff (!rst_l)
      !flush[t] |-> ((CW+2)'(fb_consume[2*t +: 2]) <= (CW+2)'(cnt_flat[CW*t +: CW]))
    );
  end

endmodule

// File: rtl/eh2_ifu_rr_arb.sv
// N-way round-robin arbiter: one-hot grant plus encoded id, search starts at ptr_q.
module eh2_ifu_rr_arb #(
  parameter int N   = 2,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gid_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [N-1:0]   gnt_s;
  logic [IDW-1:0] gid_s;
  logic           found_s;
  logic           take_s;
  int             idx_s;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    gnt_s   = '0;
    gid_s   = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s        = (int'(ptr_q) + i) % N;
      take_s       = ~found_s & req_i[idx_s];
      gnt_s[idx_s] = take_s;
      gid_s        = take_s ? IDW'(idx_s) : gid_s;
      found_s      = found_s | take_s;
    end
  end

  // Pointer moves past the winner, only when something was granted
  always_comb begin
    ptr_d = ptr_q;
    if (|req_i) begin
      ptr_d = (int'(gid_s) == N - 1) ? '0 : gid_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_s;
  assign gid_o = gid_s;

endmodule

// File: rtl/eh2_ifu_ifc_mt_ctl.sv
// Multi-thread fetch controller: per-thread pc/state/credits, round-robin F1 slot, F2 tracking.
module eh2_ifu_ifc_mt_ctl
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int FB_DEPTH    = 4,
  parameter int LINE_LOG2   = 6
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [NUM_THREADS-1:0]   flush,
  input  logic [NUM_THREADS-1:0]   flush_noredir,
  input  logic [NUM_THREADS*31-1:0] flush_path,
  input  logic                     bp_kill_f2,
  input  logic [30:0]              btb_target_f2,
  input  logic                     ic_miss_f2,
  input  logic [NUM_THREADS-1:0]   fill_done,
  input  logic [NUM_THREADS*2-1:0] fb_consume,
  input  logic                     stall,
  output logic                     fetch_req_f1,
  output logic [1:0]               fetch_tid_f1,
  output logic [30:0]              fetch_addr_f1,
  output logic                     fetch_req_f2,
  output logic [1:0]               fetch_tid_f2,
  output logic [30:0]              fetch_addr_f2,
  output logic                     line_wrap_f1,
  output logic [NUM_THREADS-1:0]   fb_full,
  output logic [NUM_THREADS-1:0]   pmu_fetch_stall
);

  localparam int CW = $clog2(FB_DEPTH + 1);

  logic [NUM_THREADS-1:0]    elig_s;
  logic [NUM_THREADS-1:0]    gnt_s;
  logic [NUM_THREADS-1:0]    kill_s;
  logic [NUM_THREADS-1:0]    miss_s;
  logic [IFC_TID_W-1:0]      gid_s;
  logic [NUM_THREADS*31-1:0] pc_all_s;
  logic [NUM_THREADS*CW-1:0] cnt_flat_s;
  logic [30:0]               f1_addr_s;
  logic [31:0]               f1_byte_s;
  logic [31:0]               f1_byte_nxt_s;
  logic                      line_wrap_s;
  logic                      f2_flush_s;

  logic                      f2_vld_q;
  logic [IFC_TID_W-1:0]      f2_tid_q;
  logic [30:0]               f2_addr_q;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    ifc_mt_state_t st_q, st_d;
    logic [30:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;
    logic          tid_f2_s;
    logic [CW+1:0] cnt_add_s, cnt_sub_s, cnt_dif_s;

    assign tid_f2_s  = (f2_tid_q == IFC_TID_W'(t));
    assign kill_s[t] = bp_kill_f2 & fetch_req_f2 & tid_f2_s;
    assign miss_s[t] = ic_miss_f2 & fetch_req_f2 & tid_f2_s;
    assign elig_s[t] = (st_q == FETCH) & (cnt_q < CW'(FB_DEPTH)) & ~stall
                     & ~flush[t] & ~kill_s[t] & ~miss_s[t];

    assign pmu_fetch_stall[t]   = (st_q == WFM) | ((st_q == FETCH) & ~elig_s[t]);
    assign fb_full[t]           = full_q;
    assign pc_all_s[31*t +: 31] = pc_q;
    assign cnt_flat_s[CW*t +: CW] = cnt_q;

    // Thread state: flush dominates, then miss entry and fill exit
    always_comb begin
      st_d = st_q;
      if (flush[t] & flush_noredir[t]) begin
        st_d = IDLE;
      end else if (flush[t]) begin
        st_d = FETCH;
      end else begin
        case (st_q)
          IDLE:    st_d = IDLE;
          FETCH:   st_d = miss_s[t] ? WFM : FETCH;
          WFM:     st_d = fill_done[t] ? FETCH : WFM;
          default: st_d = IDLE;
        endcase
      end
    end

    // Fetch pc in priority order: redirect, predicted taken, miss replay, sequential
    always_comb begin
      pc_d = pc_q;
      if (flush[t]) begin
        pc_d = flush_path[31*t +: 31];
      end else if (kill_s[t]) begin
        pc_d = btb_target_f2;
      end else if (miss_s[t]) begin
        pc_d = fetch_addr_f2;
      end else if (gnt_s[t]) begin
        pc_d = ifc_seq_next(pc_q);
      end else begin
        pc_d = pc_q;
      end
    end

    // Credits: +1 per win, minus consumed entries and a missed fetch; floor at zero
    always_comb begin
      cnt_add_s = (CW+2)'(cnt_q) + (CW+2)'(gnt_s[t]);
      cnt_sub_s = (CW+2)'(fb_consume[2*t +: 2]) + (CW+2)'(miss_s[t]);
      cnt_dif_s = cnt_add_s - cnt_sub_s;
      if (flush[t]) begin
        cnt_d = '0;
      end else if (cnt_add_s < cnt_sub_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_dif_s[CW-1:0];
      end
    end

    // Per-thread registers
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        st_q   <= IDLE;
        pc_q   <= '0;
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        pc_q   <= pc_d;
        cnt_q  <= cnt_d;
        full_q <= (cnt_d == CW'(FB_DEPTH));
      end
    end
  end

  eh2_ifu_rr_arb #(
    .N   (NUM_THREADS),
    .IDW (IFC_TID_W)
  ) u_arb (
    .clk   (clk),
    .rst_l (rst_l),
    .req_i (elig_s),
    .gnt_o (gnt_s),
    .gid_o (gid_s)
  );

  // Winner's pc onto the F1 slot and flush check against the F2 thread
  always_comb begin
    f1_addr_s  = '0;
    f2_flush_s = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      f1_addr_s  = f1_addr_s | (pc_all_s[31*t +: 31] & {31{gnt_s[t]}});
      f2_flush_s = f2_flush_s | (flush[t] & (f2_tid_q == IFC_TID_W'(t)));
    end
  end

  // Line crossing is judged on byte addresses
  always_comb begin
    f1_byte_s     = {f1_addr_s, 1'b0};
    f1_byte_nxt_s = f1_byte_s + 32'd8;
    line_wrap_s   = fetch_req_f1 & (f1_byte_s[LINE_LOG2] ^ f1_byte_nxt_s[LINE_LOG2]);
  end

  // F2 stage register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      f2_vld_q  <= 1'b0;
      f2_tid_q  <= '0;
      f2_addr_q <= '0;
    end else if (|gnt_s) begin
      f2_vld_q  <= 1'b1;
      f2_tid_q  <= gid_s;
      f2_addr_q <= f1_addr_s;
    end else begin
      f2_vld_q  <= 1'b0;
      f2_tid_q  <= f2_tid_q;
      f2_addr_q <= f2_addr_q;
    end
  end

  assign fetch_req_f1  = |gnt_s;
  assign fetch_tid_f1  = gid_s;
  assign fetch_addr_f1 = f1_addr_s;
  assign line_wrap_f1  = line_wrap_s;
  assign fetch_req_f2  = f2_vld_q & ~f2_flush_s;
  assign fetch_tid_f2  = f2_tid_q;
  assign fetch_addr_f2 = f2_addr_q;

  eh2_ifu_ifc_mt_ctl_chk #(
    .NUM_THREADS (NUM_THREADS),
    .CW          (CW)
  ) u_chk (
    .clk        (clk),
    .rst_l      (rst_l),
    .flush      (flush),
    .fb_consume (fb_consume),
    .cnt_flat   (cnt_flat_s)
  );

endmodule

// File: tb/tb_eh2_ifu_ifc_mt_ctl.sv
// Directed bench for eh2_ifu_ifc_mt_ctl with hand-computed expectations (2 threads, depth 4).
module tb_eh2_ifu_ifc_mt_ctl;

  logic        clk;
  logic        rst_l;
  logic [1:0]  flush;
  logic [1:0]  flush_noredir;
  logic [61:0] flush_path;
  logic        bp_kill_f2;
  logic [30:0] btb_target_f2;
  logic        ic_miss_f2;
  logic [1:0]  fill_done;
  logic [3:0]  fb_consume;
  logic        stall;
  logic        fetch_req_f1;
  logic [1:0]  fetch_tid_f1;
  logic [30:0] fetch_addr_f1;
  logic        fetch_req_f2;
  logic [1:0]  fetch_tid_f2;
  logic [30:0] fetch_addr_f2;
  logic        line_wrap_f1;
  logic [1:0]  fb_full;
  logic [1:0]  pmu_fetch_stall;

  int n_tests = 0;
  int n_fail  = 0;

  eh2_ifu_ifc_mt_ctl #(
    .NUM_THREADS (2),
    .FB_DEPTH    (4),
    .LINE_LOG2   (6)
  ) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .flush           (flush),
    .flush_noredir   (flush_noredir),
    .flush_path      (flush_path),
    .bp_kill_f2      (bp_kill_f2),
    .btb_target_f2   (btb_target_f2),
    .ic_miss_f2      (ic_miss_f2),
    .fill_done       (fill_done),
    .fb_consume      (fb_consume),
    .stall           (stall),
    .fetch_req_f1    (fetch_req_f1),
    .fetch_tid_f1    (fetch_tid_f1),
    .fetch_addr_f1   (fetch_addr_f1),
    .fetch_req_f2    (fetch_req_f2),
    .fetch_tid_f2    (fetch_tid_f2),
    .fetch_addr_f2   (fetch_addr_f2),
    .line_wrap_f1    (line_wrap_f1),
    .fb_full         (fb_full),
    .pmu_fetch_stall (pmu_fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_pulses();
    flush         = 2'b00;
    flush_noredir = 2'b00;
    bp_kill_f2    = 1'b0;
    ic_miss_f2    = 1'b0;
    fill_done     = 2'b00;
    fb_consume    = 4'd0;
    stall         = 1'b0;
  endtask

  // Advance to just after the next rising edge and drop all one-cycle inputs
  task automatic nxt();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  // Let combinational outputs settle; sampling happens at the falling edge
  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    clear_pulses();
    flush_path    = 62'd0;
    btb_target_f2 = 31'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  initial begin
    rst_l = 1'b1;
    clear_pulses();
    flush_path    = 62'd0;
    btb_target_f2 = 31'd0;
    #1;
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("rst_req_f1",  32'(fetch_req_f1), 32'd0);
    chk_eq("rst_addr_f1", 32'(fetch_addr_f1), 32'd0);
    chk_eq("rst_req_f2",  32'(fetch_req_f2), 32'd0);
    chk_eq("rst_addr_f2", 32'(fetch_addr_f2), 32'd0);
    chk_eq("rst_wrap",    32'(line_wrap_f1), 32'd0);
    chk_eq("rst_full",    32'(fb_full), 32'd0);
    chk_eq("rst_pmu",     32'(pmu_fetch_stall), 32'd0);

    // Single thread: redirect, four sequential wins, full, consume, stall
    do_reset();
    nxt(); flush = 2'b01; flush_path[30:0] = 31'h1000; settle();
    chk_eq("s1_flush_cycle_req", 32'(fetch_req_f1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); settle();
      chk_eq("s1_req",  32'(fetch_req_f1), 32'd1);
      chk_eq("s1_addr", 32'(fetch_addr_f1), 32'h1000 + 32'(4 * i));
      chk_eq("s1_tid",  32'(fetch_tid_f1), 32'd0);
      chk_eq("s1_full", 32'(fb_full), 32'd0);
    end
    nxt(); fb_consume = 4'd2; settle();
    chk_eq("s1_full_after4", 32'(fb_full), 32'd1);
    chk_eq("s1_req_full",    32'(fetch_req_f1), 32'd0);
    chk_eq("s1_pmu_full",    32'(pmu_fetch_stall), 32'd1);
    chk_eq("s1_f2_addr",     32'(fetch_addr_f2), 32'h100C);
    nxt(); stall = 1'b1; settle();
    chk_eq("s1_full_consumed", 32'(fb_full), 32'd0);
    chk_eq("s1_req_stall",     32'(fetch_req_f1), 32'd0);
    nxt(); settle();
    chk_eq("s1_req_resume",  32'(fetch_req_f1), 32'd1);
    chk_eq("s1_addr_resume", 32'(fetch_addr_f1), 32'h1010);

    // Two threads alternate until both fill
    do_reset();
    nxt(); flush = 2'b11; flush_path[30:0] = 31'h1000; flush_path[61:31] = 31'h2000; settle();
    for (int i = 0; i < 8; i++) begin
      nxt(); settle();
      chk_eq("s2_req",  32'(fetch_req_f1), 32'd1);
      chk_eq("s2_tid",  32'(fetch_tid_f1), 32'(i % 2));
      chk_eq("s2_addr", 32'(fetch_addr_f1),
             ((i % 2) == 1 ? 32'h2000 : 32'h1000) + 32'(4 * (i / 2)));
    end
    nxt(); settle();
    chk_eq("s2_req_done", 32'(fetch_req_f1), 32'd0);
    chk_eq("s2_full",     32'(fb_full), 32'd3);

    // Miss at 0x2008, fill three cycles later, replay from the missed address
    do_reset();
    nxt(); flush = 2'b01; flush_path[30:0] = 31'h2000; settle();
    for (int i = 0; i < 3; i++) begin
      nxt(); settle();
      chk_eq("s3_addr", 32'(fetch_addr_f1), 32'h2000 + 32'(4 * i));
    end
    nxt(); ic_miss_f2 = 1'b1; settle();
    chk_eq("s3_f2_addr",  32'(fetch_addr_f2), 32'h2008);
    chk_eq("s3_req_miss", 32'(fetch_req_f1), 32'd0);
    for (int k = 0; k < 2; k++) begin
      nxt(); settle();
      chk_eq("s3_wfm_req", 32'(fetch_req_f1), 32'd0);
      chk_eq("s3_wfm_pmu", 32'(pmu_fetch_stall), 32'd1);
    end
    nxt(); fill_done = 2'b01; settle();
    chk_eq("s3_fill_req", 32'(fetch_req_f1), 32'd0);
    nxt(); settle();
    chk_eq("s3_refetch_req",  32'(fetch_req_f1), 32'd1);
    chk_eq("s3_refetch_addr", 32'(fetch_addr_f1), 32'h2008);
    nxt(); settle();
    chk_eq("s3_seq_addr", 32'(fetch_addr_f1), 32'h200C);
    nxt(); settle();
    chk_eq("s3_req_full", 32'(fetch_req_f1), 32'd0);
    chk_eq("s3_full",     32'(fb_full), 32'd1);

    // Predicted-taken in F2 kills the same-thread F1
    do_reset();
    nxt(); flush = 2'b01; flush_path[30:0] = 31'h1000; settle();
    nxt(); settle();
    chk_eq("s4_addr", 32'(fetch_addr_f1), 32'h1000);
    nxt(); bp_kill_f2 = 1'b1; btb_target_f2 = 31'h3000; settle();
    chk_eq("s4_req_killed", 32'(fetch_req_f1), 32'd0);
    chk_eq("s4_req_f2",     32'(fetch_req_f2), 32'd1);
    nxt(); settle();
    chk_eq("s4_req_target",  32'(fetch_req_f1), 32'd1);
    chk_eq("s4_addr_target", 32'(fetch_addr_f1), 32'h3000);
    chk_eq("s4_req_f2_none", 32'(fetch_req_f2), 32'd0);

    // Thread 1: miss, then flush-to-idle during WFM, then a redirect revives it
    do_reset();
    nxt(); flush = 2'b10; flush_path[61:31] = 31'h4000; settle();
    nxt(); settle();
    chk_eq("s5_tid",  32'(fetch_tid_f1), 32'd1);
    chk_eq("s5_addr", 32'(fetch_addr_f1), 32'h4000);
    nxt(); settle();
    chk_eq("s5_addr2", 32'(fetch_addr_f1), 32'h4004);
    nxt(); ic_miss_f2 = 1'b1; settle();
    chk_eq("s5_f2_tid",   32'(fetch_tid_f2), 32'd1);
    chk_eq("s5_f2_addr",  32'(fetch_addr_f2), 32'h4004);
    chk_eq("s5_req_miss", 32'(fetch_req_f1), 32'd0);
    nxt(); flush = 2'b10; flush_noredir = 2'b10; settle();
    chk_eq("s5_pmu_wfm", 32'(pmu_fetch_stall), 32'd2);
    nxt(); settle();
    chk_eq("s5_pmu_idle", 32'(pmu_fetch_stall), 32'd0);
    chk_eq("s5_req_idle", 32'(fetch_req_f1), 32'd0);
    chk_eq("s5_full",     32'(fb_full), 32'd0);
    nxt(); fill_done = 2'b10; settle();
    chk_eq("s5_idle_fill", 32'(fetch_req_f1), 32'd0);
    nxt(); settle();
    chk_eq("s5_idle_hold", 32'(fetch_req_f1), 32'd0);
    nxt(); flush = 2'b10; flush_path[61:31] = 31'h4100; settle();
    chk_eq("s5_redir_cycle", 32'(fetch_req_f1), 32'd0);
    nxt(); settle();
    chk_eq("s5_revive_req",  32'(fetch_req_f1), 32'd1);
    chk_eq("s5_revive_tid",  32'(fetch_tid_f1), 32'd1);
    chk_eq("s5_revive_addr", 32'(fetch_addr_f1), 32'h4100);

    // Line crossing and F2 kill by a flush of the F2 thread only
    do_reset();
    nxt(); flush = 2'b01; flush_path[30:0] = 31'h103C; settle();
    nxt(); settle();
    chk_eq("s6_addr_wrap", 32'(fetch_addr_f1), 32'h103C);
    chk_eq("s6_wrap",      32'(line_wrap_f1), 32'd1);
    nxt(); flush = 2'b10; flush_noredir = 2'b10; settle();
    chk_eq("s6_f2_other_flush", 32'(fetch_req_f2), 32'd1);
    chk_eq("s6_addr_next",      32'(fetch_addr_f1), 32'h1040);
    chk_eq("s6_nowrap",         32'(line_wrap_f1), 32'd0);
    nxt(); flush = 2'b01; flush_path[30:0] = 31'h1000; settle();
    chk_eq("s6_f2_killed", 32'(fetch_req_f2), 32'd0);
    chk_eq("s6_f2_addr",   32'(fetch_addr_f2), 32'h1040);
    chk_eq("s6_f1_flush",  32'(fetch_req_f1), 32'd0);
    nxt(); settle();
    chk_eq("s6_req_redir",  32'(fetch_req_f1), 32'd1);
    chk_eq("s6_addr_redir", 32'(fetch_addr_f1), 32'h1000);
    chk_eq("s6_f2_none",    32'(fetch_req_f2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eh2_ifu_ifc_mt_ctl.md
# eh2_ifu_ifc_mt_ctl

Multi-thread instruction fetch controller: the parametrised successor of the single-thread IFC.
- Holds one fetch PC, one state machine and one fetch-buffer credit counter per thread.
- Round-robin arbitrates the eligible threads onto a single F1 fetch slot, and tracks the F2 stage.
- Sits between the decode/TLU redirect sources and the I-cache/ICCM fetch pipeline. The fetch buffer depth, thread count and line size are parameters rather than fixed.

## Interface
Parameters:
- NUM_THREADS, 2, thread count, 1..4.
- FB_DEPTH, 4, fetch-buffer entries per thread, 2..8.
- LINE_LOG2, 6, log2 of I-cache line bytes.

Ports:
- clk  in  1  single clock; all state on this clock.
- rst_l  in  1  reset, asynchronous, active-low.
- flush  in  NUM_THREADS  per-thread redirect.
- flush_noredir  in  NUM_THREADS  flush sends thread to IDLE; qualifies flush.
- flush_path  in  NUM_THREADS*31  per-thread redirect address [31:1], thread t at [31t+30:31t].
- bp_kill_f2  in  1  predicted-taken on the F2 fetch; valid only with fetch_req_f2.
- btb_target_f2  in  31  predicted target [31:1].
- ic_miss_f2  in  1  F2 fetch missed; valid only with fetch_req_f2.
- fill_done  in  NUM_THREADS  miss buffer empty for the thread.
- fb_consume  in  NUM_THREADS*2  entries consumed this cycle (0/1/2).
- stall  in  1  global stall (DMA or I-cache write).
- fetch_req_f1  out  1  F1 fetch valid.
- fetch_tid_f1  out  2  F1 thread.
- fetch_addr_f1  out  31  F1 address.
- fetch_req_f2  out  1  registered F2 valid.
- fetch_tid_f2  out  2  F2 thread.
- fetch_addr_f2  out  31  F2 address.
- line_wrap_f1  out  1  the next sequential fetch of the F1 thread crosses a line.
- fb_full  out  NUM_THREADS  credit count == FB_DEPTH.
- pmu_fetch_stall  out  NUM_THREADS  thread in WFM, or in FETCH and not eligible.

## Operation
Per-thread state machine: IDLE, FETCH, WFM. Reset state is IDLE.
- IDLE -> FETCH on flush & ~flush_noredir.
- Any state -> IDLE on flush & flush_noredir.
- FETCH -> WFM on fetch_req_f2 & ic_miss_f2 & fetch_tid_f2 == t, unless flush[t].
- WFM -> FETCH on fill_done[t] & ~flush[t].

Eligibility of thread t:
- state FETCH, count < FB_DEPTH, ~stall, ~flush[t].
- Not killed or missing in F2 this cycle.

Arbitration and F1:
- Round-robin among eligible threads, starting at last winner + 1.
- Winner drives fetch_req_f1, fetch_tid_f1 and fetch_addr_f1 = pc[t].
- fetch_req_f1 is combinational from registered state and this cycle's inputs.

PC update per thread, highest priority first:
1. flush: pc <- flush_path.
2. bp_kill_f2 on t: pc <- btb_target_f2.
3. ic_miss_f2 on t: pc <- fetch_addr_f2.
4. Winner: pc <- {pc[31:3]+1, 2'b00}.
5. Otherwise hold.

Credit counter, width $clog2(FB_DEPTH+1):
- next = count + win - consume - miss_return.
- miss_return = 1 when F2 missed for t.
- flush[t] forces count <- 0, regardless of consume.
- Consume greater than count is illegal; the counter saturates at 0 and an assertion fires.

F2 register:
- Loads on win; F2 valid clears when there is no win.
- flush of fetch_tid_f2 kills fetch_req_f2 combinationally that cycle.
- A flush on another thread does not affect F2.

line_wrap_f1: bit LINE_LOG2 of addr+8 differs from bit LINE_LOG2 of addr.

Reset values:
- All states IDLE; pc, count, F2 and arbiter pointer 0.
- Therefore all outputs are 0 except pmu_fetch_stall = 0 (IDLE is not a stall).

## Timing
- F1 -> F2 latency is 1 cycle.
- A redirect in cycle n makes the thread eligible in cycle n+1 with the new pc.
- A miss in cycle n gives WFM in n+1. The first refetch of fetch_addr_f2 occurs the cycle after fill_done is seen in WFM.
- A bp_kill on t in cycle n suppresses t's F1 in cycle n. Another eligible thread may win in that cycle.
- fb_full is registered, reflecting count after the cycle-n update.
- Back-to-back wins for a single eligible thread every cycle, until count reaches FB_DEPTH.

## Structure
- Add to eh2_pkg:
  - typedef enum logic [1:0] ifc_mt_state_t {IDLE=0, FETCH=1, WFM=3}.
  - Localparam IFC_MAX_THREADS = 4.
- Sub-module eh2_ifu_rr_arb: parametrised N-way round-robin arbiter. It takes a request vector, outputs a one-hot grant plus an encoded id, and updates its pointer only on grant.
- Per-thread logic lives in a generate loop.

## Test plan
- Reset, then flush[0] with path 0x1000 and ~noredir -> next cycle fetch_req_f1=1, addr 0x1000, tid 0. Addresses then step 0x1004, 0x1008, 0x100C with no consume. fb_full[0]=1 after 4 wins and fetch_req_f1=0.
- Two threads flushed together, no consume -> tids alternate 0,1,0,1 until both are full.
- Thread 0 F2 ic_miss_f2 at addr 0x2008 -> state WFM, count decremented by 1. fill_done 3 cycles later -> next-cycle F1 addr 0x2008.
- bp_kill_f2 with target 0x3000 while thread 0 wins in F1 -> that F1 is suppressed, and the next thread 0 fetch is at 0x3000.
- flush with noredir on thread 1 during WFM -> IDLE, count 0, no fetches until a redirect flush arrives.
- LINE_LOG2=6 with pc 0x103C -> line_wrap_f1=1, next address 0x1040. Simultaneous flush on tid_f2 -> fetch_req_f2=0 that cycle.
